// File: rtl/turfio_event_gate.sv
// Per-TURFIO event-stream gate. Each channel forwards unmasked frames with
// zero-latency passthrough and backpressure. Masked frames are drained and
// discarded. Frames longer than MAX_BEATS are cut short and flagged.
//
// Handshake: a beat transfers on a cycle where tvalid && tready are both high
// at the rising edge of aclk. tvalid never waits on tready. On the downstream
// side, tready is only combinationally forwarded upstream while the channel is
// forwarding.
module turfio_event_gate #(
  parameter int NUM_TIO    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 4096
) (
  input  logic                          aclk,
  input  logic                          rst_i,
  input  logic [NUM_TIO-1:0]            tio_mask_i,
  input  logic [NUM_TIO*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_TIO-1:0]            s_tvalid,
  input  logic [NUM_TIO-1:0]            s_tlast,
  output logic [NUM_TIO-1:0]            s_tready,
  output logic [NUM_TIO*DATA_WIDTH-1:0] m_tdata,
  output logic [NUM_TIO-1:0]            m_tvalid,
  output logic [NUM_TIO-1:0]            m_tlast,
  input  logic [NUM_TIO-1:0]            m_tready,
  output logic [NUM_TIO*32-1:0]         pass_count_o,
  output logic [NUM_TIO*32-1:0]         drop_count_o,
  output logic [NUM_TIO-1:0]            overflow_o
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2,
    ST_TRUNC = 2'd3
  } state_t;

  // Data path is a pure wire; only valid/ready/last are gated.
  assign m_tdata = s_tdata;

  for (genvar n = 0; n < NUM_TIO; n++) begin : g_ch
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_beats;
    logic [CW-1:0] w_beats_nxt;
    logic [31:0]   r_pass;
    logic [31:0]   r_drop;
    logic          r_ovf;
    logic          w_fwd;
    logic          w_rdy;
    logic          w_acc;
    logic          w_last_out;
    logic          w_pass_inc;
    logic          w_drop_inc;
    logic          w_ovf_set;

    // Forwarding happens in PASS and in unmasked IDLE; the mask only matters in IDLE.
    assign w_fwd = (r_state == ST_PASS) || ((r_state == ST_IDLE) && !tio_mask_i[n]);
    assign w_rdy = !rst_i && (w_fwd ? m_tready[n] : 1'b1);
    assign w_acc = s_tvalid[n] && w_rdy;

    assign s_tready[n]         = w_rdy;
    assign m_tvalid[n]         = !rst_i && w_fwd && s_tvalid[n];
    assign m_tlast[n]          = w_last_out;
    assign pass_count_o[n*32 +: 32] = r_pass;
    assign drop_count_o[n*32 +: 32] = r_drop;
    assign overflow_o[n]       = r_ovf;

    // Next-state, frame bookkeeping and forced-tlast decode.
    always_comb begin
      w_state_nxt = r_state;
      w_beats_nxt = r_beats;
      w_last_out  = s_tlast[n];
      w_pass_inc  = 1'b0;
      w_drop_inc  = 1'b0;
      w_ovf_set   = 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_beats_nxt = '0;
          if (w_acc) begin
            if (tio_mask_i[n]) begin
              if (s_tlast[n]) w_drop_inc  = 1'b1;
              else            w_state_nxt = ST_DROP;
            end else begin
              if (s_tlast[n]) begin
                w_pass_inc = 1'b1;
              end else begin
                w_beats_nxt = CW'(1);
                w_state_nxt = ST_PASS;
              end
            end
          end
        end
        ST_PASS: begin
          if (w_acc) begin
            w_beats_nxt = r_beats + CW'(1);
            if (s_tlast[n]) begin
              w_pass_inc  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else if (r_beats == CW'(MAX_BEATS - 1)) begin
              // This beat is number MAX_BEATS: end the frame downstream here.
              w_last_out  = 1'b1;
              w_ovf_set   = 1'b1;
              w_pass_inc  = 1'b1;
              w_state_nxt = ST_TRUNC;
            end
          end
        end
        ST_DROP: begin
          if (w_acc && s_tlast[n]) begin
            w_drop_inc  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_TRUNC: begin
          if (w_acc && s_tlast[n]) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // State register; reset abandons any partial frame.
    always_ff @(posedge aclk) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
    end

    // Beat counter, wrapping frame counters and sticky overflow flag.
    always_ff @(posedge aclk) begin
      if (rst_i) begin
        r_beats <= '0;
        r_pass  <= '0;
        r_drop  <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_beats <= w_beats_nxt;
        if (w_pass_inc) r_pass <= r_pass + 32'd1;
        if (w_drop_inc) r_drop <= r_drop + 32'd1;
        if (w_ovf_set)  r_ovf  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/turfio_event_gate.md
Name: turfio_event_gate

Overview:
- Per-TURFIO event-stream gate in the aclk domain, directly downstream of the event register block.
- Consumes the synchronized TURFIO mask (tio_mask_aclk) and event reset (event_reset_aclk).
- Takes the NUM_TIO Aurora event streams and passes unmasked frames downstream with backpressure; masked frames are drained and discarded.
- Mask changes apply only on frame boundaries. Oversize frames are truncated and flagged.
- Per-channel frame statistics are produced for the wishbone register space.

Parameters:
- NUM_TIO, 4, number of TURFIO stream channels.
- DATA_WIDTH, 32, tdata width per channel.
- MAX_BEATS, 4096, maximum beats per frame before forced truncation (>=2).

Ports:
- aclk  input  1  stream clock.
- rst_i  input  1  synchronous active-high reset, driven by event_reset_aclk.
- tio_mask_i  input  NUM_TIO  1 = channel masked (frames discarded).
- s_tdata  input  NUM_TIO*DATA_WIDTH  upstream data; channel n at [n*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  input  NUM_TIO  upstream valid.
- s_tlast  input  NUM_TIO  upstream end of frame.
- s_tready  output  NUM_TIO  upstream ready.
- m_tdata  output  NUM_TIO*DATA_WIDTH  downstream data.
- m_tvalid  output  NUM_TIO  downstream valid.
- m_tlast  output  NUM_TIO  downstream end of frame (may be forced on truncation).
- m_tready  input  NUM_TIO  downstream ready.
- pass_count_o  output  NUM_TIO*32  frames forwarded, per channel.
- drop_count_o  output  NUM_TIO*32  frames discarded because masked, per channel.
- overflow_o  output  NUM_TIO  sticky: a frame exceeded MAX_BEATS.

Behaviour:
- Channels are fully independent. Each has a FSM {IDLE, PASS, DROP, TRUNC}, a beat counter of width $clog2(MAX_BEATS+1), and two 32-bit frame counters.
- Beat accepted on s_tvalid && s_tready. Data path is combinational: zero latency, m_tdata = s_tdata always.
- IDLE, tio_mask_i[n]=0: s_tready = m_tready, m_tvalid = s_tvalid, m_tlast = s_tlast.
  - Accepted beat with tlast: pass_count++, stay IDLE.
  - Accepted beat without tlast: beat count = 1, go PASS.
- IDLE, tio_mask_i[n]=1: s_tready = 1, m_tvalid = 0.
  - Accepted beat with tlast: drop_count++, stay IDLE.
  - Accepted beat without tlast: go DROP.
- The mask is sampled only in IDLE, on the cycle the first beat is accepted. Mask changes while in PASS/DROP/TRUNC have no effect until the next IDLE.
- PASS: same handshake as unmasked IDLE; beat count increments per accepted beat.
  - Accepted tlast: pass_count++, go IDLE.
  - Accepted beat that is beat number MAX_BEATS without tlast: m_tlast forced 1 on that beat, overflow_o[n] set, pass_count++, go TRUNC.
  - tlast exactly on beat MAX_BEATS: normal end, no overflow.
- TRUNC: s_tready = 1, m_tvalid = 0, beats discarded; accepted tlast goes to IDLE. No counter changes.
- DROP: s_tready = 1, m_tvalid = 0; accepted tlast gives drop_count++ and goes to IDLE. There is no length limit in DROP.
- m_tvalid never asserts in DROP/TRUNC. s_tready never depends on m_tready in DROP/TRUNC/masked IDLE.
- Counters wrap 0xFFFFFFFF -> 0 and do not saturate. overflow_o stays set until rst_i.
- Reset, applied any cycle including mid-frame:
  - All FSMs go to IDLE; beat counters, pass/drop counts and overflow_o go to 0.
  - s_tready = 0 and m_tvalid = 0 while rst_i = 1.
  - The partial frame is abandoned with no tlast emitted; downstream shares the same reset.
  - The first beat after reset starts a new frame.
- Reset values of outputs: s_tready = 0 (during reset), m_tvalid = 0, m_tlast = s_tlast passthrough (don't-care while m_tvalid = 0), counts 0, overflow_o 0.

Test Plan:
- Mask 0000; channel 0 sends a 3-beat frame with m_tready=1 -> 3 output beats, data identical, tlast on beat 3; pass_count[0]=1, drop_count[0]=0.
- Mask 0010; channel 1 sends two 5-beat frames with m_tready held 0 -> s_tready[1]=1 throughout, m_tvalid[1] never 1, drop_count[1]=2.
- Channel 2 frame in progress (beat 2 of 6); set mask bit 2 mid-frame -> remaining 4 beats still forwarded and pass_count[2]=1; next frame dropped, drop_count[2]=1.
- MAX_BEATS=8; channel 3 sends 12 beats then tlast -> 8 beats out with m_tlast forced on beat 8, overflow_o[3]=1, beats 9-12 and tlast consumed silently; a following 8-beat frame passes with no new effect.
- Channel 0 unmasked, m_tready toggled 1010... over a 4-beat frame -> s_tready mirrors m_tready each cycle, no beat lost or duplicated.
- Assert rst_i for 1 cycle in mid-frame on all channels with nonzero counts -> counts and overflow 0, s_tready 0 during reset; the next single-beat tlast frame counts as exactly one frame.
